// File: rtl/axi4_ar_drop_sender.sv
// Read-address stage of the RAB slave port: buffers AR requests, hands each head entry to the
// lookup core, then forwards it translated on the master AR channel or issues a drop to the R sender.
module axi4_ar_drop_sender #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 4,
  parameter int unsigned BUFFER_DEPTH   = 4
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,

  input  logic [AXI_ID_WIDTH-1:0]   s_axi4_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi4_araddr,
  input  logic [7:0]                s_axi4_arlen,
  input  logic [2:0]                s_axi4_arsize,
  input  logic [1:0]                s_axi4_arburst,
  input  logic                      s_axi4_arlock,
  input  logic [2:0]                s_axi4_arprot,
  input  logic [3:0]                s_axi4_arcache,
  input  logic [3:0]                s_axi4_arregion,
  input  logic [3:0]                s_axi4_arqos,
  input  logic [AXI_USER_WIDTH-1:0] s_axi4_aruser,
  input  logic                      s_axi4_arvalid,
  output logic                      s_axi4_arready,

  output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
  output logic [7:0]                m_axi4_arlen,
  output logic [2:0]                m_axi4_arsize,
  output logic [1:0]                m_axi4_arburst,
  output logic                      m_axi4_arlock,
  output logic [2:0]                m_axi4_arprot,
  output logic [3:0]                m_axi4_arcache,
  output logic [3:0]                m_axi4_arregion,
  output logic [3:0]                m_axi4_arqos,
  output logic [AXI_USER_WIDTH-1:0] m_axi4_aruser,
  output logic                      m_axi4_arvalid,
  input  logic                      m_axi4_arready,

  output logic                      lookup_req_o,
  output logic [AXI_ADDR_WIDTH-1:0] lookup_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   lookup_id_o,
  output logic [2:0]                lookup_prot_o,
  input  logic                      accept_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_addr_i,
  input  logic                      drop_i,
  input  logic                      prefetch_i,
  input  logic                      hit_i,

  output logic                      drop_o,
  output logic [7:0]                drop_len_o,
  output logic [AXI_ID_WIDTH-1:0]   drop_id_o,
  output logic                      drop_prefetch_o,
  output logic                      drop_hit_o,
  input  logic                      drop_done_i
);

  localparam int unsigned PtrW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [PtrW:0] Full = (PtrW+1)'(BUFFER_DEPTH);

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [2:0]                prot;
    logic [3:0]                cache;
    logic [3:0]                region;
    logic [3:0]                qos;
    logic [AXI_USER_WIDTH-1:0] user;
  } ar_t;

  typedef enum logic [1:0] {StIdle, StLookup, StForward, StDrop} state_e;

  ar_t                      mem_q [BUFFER_DEPTH];
  ar_t                      mem_d [BUFFER_DEPTH];
  ar_t                      ar_in;
  ar_t                      head;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]            count_q, count_d;
  state_e                   state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] trans_addr_q, trans_addr_d;
  logic                     prefetch_q, prefetch_d;
  logic                     hit_q, hit_d;
  logic                     pop_q, pop_d;
  logic                     push, pop, empty, fwd, drp;

  assign ar_in = '{id: s_axi4_arid, addr: s_axi4_araddr, len: s_axi4_arlen,
                   size: s_axi4_arsize, burst: s_axi4_arburst, lock: s_axi4_arlock,
                   prot: s_axi4_arprot, cache: s_axi4_arcache, region: s_axi4_arregion,
                   qos: s_axi4_arqos, user: s_axi4_aruser};

  assign head           = mem_q[rd_ptr_q];
  assign empty          = (count_q == '0);
  // Full check alone blocks push-while-full, even in a cycle where the head pops.
  assign s_axi4_arready = (count_q != Full);
  assign push           = s_axi4_arvalid & s_axi4_arready;
  assign fwd            = (state_q == StForward);
  assign drp            = (state_q == StDrop);
  assign pop            = (fwd & m_axi4_arready) | (drp & drop_done_i);

  // pop_q holds off the next lookup one cycle after a completion.
  assign lookup_req_o  = (state_q == StIdle) & ~empty & ~pop_q;
  assign lookup_addr_o = head.addr;
  assign lookup_id_o   = head.id;
  assign lookup_prot_o = head.prot;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = ar_in;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    trans_addr_d = trans_addr_q;
    prefetch_d   = prefetch_q;
    hit_d        = hit_q;
    pop_d        = pop;
    unique case (state_q)
      StIdle: begin
        if (lookup_req_o) state_d = StLookup;
      end
      StLookup: begin
        if (drop_i) begin
          state_d    = StDrop;
          prefetch_d = prefetch_i;
          hit_d      = hit_i;
        end else if (accept_i) begin
          state_d      = StForward;
          trans_addr_d = trans_addr_i;
        end
      end
      StForward: begin
        if (m_axi4_arready) state_d = StIdle;
      end
      StDrop: begin
        if (drop_done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= StIdle;
      trans_addr_q <= '0;
      prefetch_q   <= 1'b0;
      hit_q        <= 1'b0;
      pop_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      trans_addr_q <= trans_addr_d;
      prefetch_q   <= prefetch_d;
      hit_q        <= hit_d;
      pop_q        <= pop_d;
    end
  end

  // Channel outputs are zeroed outside their state so nothing leaks while idle.
  always_comb begin
    m_axi4_arvalid  = fwd;
    m_axi4_arid     = fwd ? head.id     : '0;
    m_axi4_araddr   = fwd ? trans_addr_q : '0;
    m_axi4_arlen    = fwd ? head.len    : '0;
    m_axi4_arsize   = fwd ? head.size   : '0;
    m_axi4_arburst  = fwd ? head.burst  : '0;
    m_axi4_arlock   = fwd ? head.lock   : 1'b0;
    m_axi4_arprot   = fwd ? head.prot   : '0;
    m_axi4_arcache  = fwd ? head.cache  : '0;
    m_axi4_arregion = fwd ? head.region : '0;
    m_axi4_arqos    = fwd ? head.qos    : '0;
    m_axi4_aruser   = fwd ? head.user   : '0;

    drop_o          = drp;
    drop_len_o      = drp ? head.len : '0;
    drop_id_o       = drp ? head.id  : '0;
    drop_prefetch_o = drp & prefetch_q;
    drop_hit_o      = drp & hit_q;
  end

endmodule

// File: tb/tb_axi4_ar_drop_sender.sv
// Directed bench for axi4_ar_drop_sender: accept, drop, back-pressure, full FIFO, conflicts, reset.
module tb_axi4_ar_drop_sender;

  logic        clk = 1'b0;
  logic        arstn;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arlock;
  logic [2:0]  s_arprot;
  logic [3:0]  s_arcache, s_arregion, s_arqos, s_aruser;
  logic        s_arvalid, s_arready;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arlock;
  logic [2:0]  m_arprot;
  logic [3:0]  m_arcache, m_arregion, m_arqos, m_aruser;
  logic        m_arvalid, m_arready;
  logic        lookup_req;
  logic [31:0] lookup_addr;
  logic [3:0]  lookup_id;
  logic [2:0]  lookup_prot;
  logic        accept, drop, prefetch, hit;
  logic [31:0] trans_addr;
  logic        drop_o, drop_pf, drop_hit, drop_done;
  logic [7:0]  drop_len;
  logic [3:0]  drop_id;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi4_ar_drop_sender #(
    .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4), .BUFFER_DEPTH(4)
  ) dut (
    .axi4_aclk(clk), .axi4_arstn(arstn),
    .s_axi4_arid(s_arid), .s_axi4_araddr(s_araddr), .s_axi4_arlen(s_arlen),
    .s_axi4_arsize(s_arsize), .s_axi4_arburst(s_arburst), .s_axi4_arlock(s_arlock),
    .s_axi4_arprot(s_arprot), .s_axi4_arcache(s_arcache), .s_axi4_arregion(s_arregion),
    .s_axi4_arqos(s_arqos), .s_axi4_aruser(s_aruser), .s_axi4_arvalid(s_arvalid),
    .s_axi4_arready(s_arready),
    .m_axi4_arid(m_arid), .m_axi4_araddr(m_araddr), .m_axi4_arlen(m_arlen),
    .m_axi4_arsize(m_arsize), .m_axi4_arburst(m_arburst), .m_axi4_arlock(m_arlock),
    .m_axi4_arprot(m_arprot), .m_axi4_arcache(m_arcache), .m_axi4_arregion(m_arregion),
    .m_axi4_arqos(m_arqos), .m_axi4_aruser(m_aruser), .m_axi4_arvalid(m_arvalid),
    .m_axi4_arready(m_arready),
    .lookup_req_o(lookup_req), .lookup_addr_o(lookup_addr), .lookup_id_o(lookup_id),
    .lookup_prot_o(lookup_prot), .accept_i(accept), .trans_addr_i(trans_addr),
    .drop_i(drop), .prefetch_i(prefetch), .hit_i(hit),
    .drop_o(drop_o), .drop_len_o(drop_len), .drop_id_o(drop_id),
    .drop_prefetch_o(drop_pf), .drop_hit_o(drop_hit), .drop_done_i(drop_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    s_arid    = id;
    s_araddr  = addr;
    s_arlen   = len;
    s_arvalid = 1'b1;
  endtask

  task automatic wait_lookup(input string tag);
    for (int n = 0; n < 20 && !lookup_req; n++) tick();
    chk(tag, {63'd0, lookup_req}, 64'd1);
  endtask

  task automatic serve(input logic [3:0] id, input logic [31:0] taddr);
    wait_lookup("serve_lookup_req");
    chk("serve_lookup_id", {60'd0, lookup_id}, {60'd0, id});
    tick();
    accept = 1'b1;
    trans_addr = taddr;
    tick();
    accept = 1'b0;
    chk("serve_arvalid", {63'd0, m_arvalid}, 64'd1);
    chk("serve_arid", {60'd0, m_arid}, {60'd0, id});
    chk("serve_araddr", {32'd0, m_araddr}, {32'd0, taddr});
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  initial begin
    arstn = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0;
    s_arsize = 3'd2; s_arburst = 2'd1; s_arlock = 1'b0; s_arprot = 3'd2;
    s_arcache = 4'h3; s_arregion = 4'h0; s_arqos = 4'h5; s_aruser = 4'h9;
    m_arready = 1'b0; accept = 1'b0; drop = 1'b0; prefetch = 1'b0; hit = 1'b0;
    trans_addr = '0; drop_done = 1'b0;
    repeat (2) tick();
    chk("rst_arready", {63'd0, s_arready}, 64'd1);
    chk("rst_arvalid", {63'd0, m_arvalid}, 64'd0);
    chk("rst_drop", {63'd0, drop_o}, 64'd0);
    chk("rst_lookup_req", {63'd0, lookup_req}, 64'd0);
    chk("rst_araddr", {32'd0, m_araddr}, 64'd0);
    arstn = 1'b1;
    tick();

    // Accept path
    set_ar(4'd3, 32'h0000_1000, 8'd7);
    tick();
    s_arvalid = 1'b0;
    chk("acc_lookup_req", {63'd0, lookup_req}, 64'd1);
    chk("acc_lookup_addr", {32'd0, lookup_addr}, 64'h1000);
    chk("acc_lookup_id", {60'd0, lookup_id}, 64'd3);
    chk("acc_lookup_prot", {61'd0, lookup_prot}, 64'd2);
    tick();
    chk("acc_req_pulse", {63'd0, lookup_req}, 64'd0);
    tick();
    accept = 1'b1;
    trans_addr = 32'h8000_1000;
    tick();
    accept = 1'b0;
    chk("acc_arvalid", {63'd0, m_arvalid}, 64'd1);
    chk("acc_araddr", {32'd0, m_araddr}, 64'h8000_1000);
    chk("acc_arid", {60'd0, m_arid}, 64'd3);
    chk("acc_arlen", {56'd0, m_arlen}, 64'd7);
    chk("acc_arsize", {61'd0, m_arsize}, 64'd2);
    chk("acc_arqos", {60'd0, m_arqos}, 64'd5);
    chk("acc_aruser", {60'd0, m_aruser}, 64'd9);
    chk("acc_drop", {63'd0, drop_o}, 64'd0);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("acc_arvalid_done", {63'd0, m_arvalid}, 64'd0);
    chk("acc_arready", {63'd0, s_arready}, 64'd1);
    tick();
    chk("acc_empty_no_req", {63'd0, lookup_req}, 64'd0);

    // Drop path with done held off
    set_ar(4'd5, 32'h0000_2000, 8'd3);
    tick();
    s_arvalid = 1'b0;
    chk("drp_lookup_req", {63'd0, lookup_req}, 64'd1);
    tick();
    drop = 1'b1; prefetch = 1'b1; hit = 1'b0;
    tick();
    drop = 1'b0; prefetch = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("drp_drop_o", {63'd0, drop_o}, 64'd1);
      chk("drp_len", {56'd0, drop_len}, 64'd3);
      chk("drp_id", {60'd0, drop_id}, 64'd5);
      chk("drp_prefetch", {63'd0, drop_pf}, 64'd1);
      chk("drp_hit", {63'd0, drop_hit}, 64'd0);
      chk("drp_no_arvalid", {63'd0, m_arvalid}, 64'd0);
      if (i == 4) drop_done = 1'b1;
      tick();
    end
    drop_done = 1'b0;
    chk("drp_drop_clear", {63'd0, drop_o}, 64'd0);
    chk("drp_arready", {63'd0, s_arready}, 64'd1);
    tick();
    chk("drp_popped", {63'd0, lookup_req}, 64'd0);

    // Back-pressure with a second entry queued behind
    set_ar(4'd1, 32'h0000_3000, 8'd2);
    tick();
    chk("bp_lookup_id", {60'd0, lookup_id}, 64'd1);
    set_ar(4'd2, 32'h0000_4000, 8'd1);
    tick();
    s_arvalid = 1'b0;
    accept = 1'b1;
    trans_addr = 32'h9000_3000;
    tick();
    accept = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_arvalid", {63'd0, m_arvalid}, 64'd1);
      chk("bp_araddr", {32'd0, m_araddr}, 64'h9000_3000);
      chk("bp_arid", {60'd0, m_arid}, 64'd1);
      chk("bp_arlen", {56'd0, m_arlen}, 64'd2);
      chk("bp_no_req", {63'd0, lookup_req}, 64'd0);
      tick();
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("bp_arvalid_done", {63'd0, m_arvalid}, 64'd0);
    chk("bp_req_gap", {63'd0, lookup_req}, 64'd0);
    tick();
    chk("bp_next_req", {63'd0, lookup_req}, 64'd1);
    chk("bp_next_id", {60'd0, lookup_id}, 64'd2);

    // Accept and drop together: drop wins
    tick();
    accept = 1'b1; drop = 1'b1; hit = 1'b1; prefetch = 1'b0; trans_addr = 32'hFFFF_0000;
    tick();
    accept = 1'b0; drop = 1'b0; hit = 1'b0;
    chk("cf_drop_o", {63'd0, drop_o}, 64'd1);
    chk("cf_no_arvalid", {63'd0, m_arvalid}, 64'd0);
    chk("cf_hit", {63'd0, drop_hit}, 64'd1);
    chk("cf_id", {60'd0, drop_id}, 64'd2);
    chk("cf_len", {56'd0, drop_len}, 64'd1);
    drop_done = 1'b1;
    tick();
    drop_done = 1'b0;
    chk("cf_drop_clear", {63'd0, drop_o}, 64'd0);

    // Stray accept in IDLE
    tick();
    accept = 1'b1;
    trans_addr = 32'h1234_5678;
    tick();
    accept = 1'b0;
    chk("stray_arvalid", {63'd0, m_arvalid}, 64'd0);
    chk("stray_req", {63'd0, lookup_req}, 64'd0);
    tick();
    chk("stray_arvalid2", {63'd0, m_arvalid}, 64'd0);

    // FIFO full
    for (int i = 0; i < 4; i++) begin
      chk("full_arready_pre", {63'd0, s_arready}, 64'd1);
      set_ar(4'(i), 32'h0000_5000 + 32'(i * 16), 8'(i));
      tick();
    end
    set_ar(4'd4, 32'h0000_5040, 8'd4);
    chk("full_arready0", {63'd0, s_arready}, 64'd0);
    tick();
    chk("full_stall", {63'd0, s_arready}, 64'd0);
    chk("full_head_id", {60'd0, lookup_id}, 64'd0);
    accept = 1'b1;
    trans_addr = 32'hA000_0000;
    tick();
    accept = 1'b0;
    chk("full_arvalid0", {63'd0, m_arvalid}, 64'd1);
    chk("full_arid0", {60'd0, m_arid}, 64'd0);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("full_arvalid0_done", {63'd0, m_arvalid}, 64'd0);
    chk("full_arready_pop", {63'd0, s_arready}, 64'd1);
    tick();
    s_arvalid = 1'b0;
    chk("full_refilled", {63'd0, s_arready}, 64'd0);
    for (int k = 1; k < 5; k++) serve(4'(k), 32'hA000_0000 + 32'(k));
    tick();
    chk("full_drained_req", {63'd0, lookup_req}, 64'd0);
    chk("full_drained_ready", {63'd0, s_arready}, 64'd1);

    // Reset while forwarding with entries queued
    for (int i = 0; i < 4; i++) begin
      set_ar(4'(7 + i), 32'h0000_7000 + 32'(i * 16), 8'd0);
      tick();
    end
    s_arvalid = 1'b0;
    accept = 1'b1;
    trans_addr = 32'hB000_7000;
    tick();
    accept = 1'b0;
    chk("rm_arvalid", {63'd0, m_arvalid}, 64'd1);
    chk("rm_arid", {60'd0, m_arid}, 64'd7);
    arstn = 1'b0;
    #1;
    chk("rm_arvalid_async", {63'd0, m_arvalid}, 64'd0);
    chk("rm_drop_async", {63'd0, drop_o}, 64'd0);
    chk("rm_arready_async", {63'd0, s_arready}, 64'd1);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    tick();
    tick();
    chk("rm_no_req", {63'd0, lookup_req}, 64'd0);
    chk("rm_arready", {63'd0, s_arready}, 64'd1);
    chk("rm_no_arvalid", {63'd0, m_arvalid}, 64'd0);
    set_ar(4'd11, 32'h0000_6000, 8'd0);
    tick();
    s_arvalid = 1'b0;
    chk("rm_new_req", {63'd0, lookup_req}, 64'd1);
    chk("rm_new_id", {60'd0, lookup_id}, 64'd11);
    chk("rm_new_addr", {32'd0, lookup_addr}, 64'h6000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
